// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the load/store unit (port 0) and a secondary requester
// (port 1) in front of the shared data memory, which samples its inputs on negedge.
module dmem_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_e            state_q;
    logic              lastGrant_q;
    logic              winner_q;
    logic              winWr_q;
    logic [3:0]        waitCnt_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [DATA_W-1:0] memDin_q;
    logic              memWen_q;
    logic              memRen_q;
    logic              p0Ack_q;
    logic              p1Ack_q;
    logic [DATA_W-1:0] p0Rdata_q;
    logic [DATA_W-1:0] p1Rdata_q;

    logic              grantValid;
    logic              grantPort;
    logic              selWr;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;

    // A lone requester always wins; on contention the port that did not win last time goes first.
    always_comb begin
        grantValid = p0_req | p1_req;
        grantPort  = p1_req;
        if (p0_req && p1_req) begin
            grantPort = ~lastGrant_q;
        end
        selWr    = grantPort ? p1_wr    : p0_wr;
        selAddr  = grantPort ? p1_addr  : p0_addr;
        selWdata = grantPort ? p1_wdata : p0_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            winner_q    <= 1'b0;
            winWr_q     <= 1'b0;
            waitCnt_q   <= '0;
            memAddr_q   <= '0;
            memDin_q    <= '0;
            memWen_q    <= 1'b0;
            memRen_q    <= 1'b0;
            p0Ack_q     <= 1'b0;
            p1Ack_q     <= 1'b0;
            p0Rdata_q   <= '0;
            p1Rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantValid) begin
                        winner_q    <= grantPort;
                        winWr_q     <= selWr;
                        memAddr_q   <= selAddr;
                        memDin_q    <= selWdata;
                        memWen_q    <= selWr;
                        memRen_q    <= ~selWr;
                        lastGrant_q <= grantPort;
                        waitCnt_q   <= CNT_INIT;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (waitCnt_q == 4'd0) begin
                        // mem_dout is only meaningful here, at the end of a read window.
                        if (!winWr_q) begin
                            if (winner_q) begin
                                p1Rdata_q <= mem_dout;
                            end else begin
                                p0Rdata_q <= mem_dout;
                            end
                        end
                        memAddr_q <= '0;
                        memDin_q  <= '0;
                        memWen_q  <= 1'b0;
                        memRen_q  <= 1'b0;
                        p0Ack_q   <= ~winner_q;
                        p1Ack_q   <= winner_q;
                        state_q   <= DONE;
                    end else begin
                        waitCnt_q <= waitCnt_q - 4'd1;
                    end
                end
                DONE: begin
                    p0Ack_q <= 1'b0;
                    p1Ack_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr = memAddr_q;
    assign mem_din  = memDin_q;
    assign mem_wen  = memWen_q;
    assign mem_ren  = memRen_q;
    assign p0_ack   = p0Ack_q;
    assign p1_ack   = p1Ack_q;
    assign p0_rdata = p0Rdata_q;
    assign p1_rdata = p1Rdata_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance A uses one access cycle, instance B three; both share
// requester inputs and each has its own negedge-sampled memory model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        p0_req, p0_wr, p1_req, p1_wr;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

    logic        ackA0, ackA1, memWenA, memRenA, busyA;
    logic [15:0] rdataA0, rdataA1, memAddrA, memDinA, memDoutA;
    logic        ackB0, ackB1, memWenB, memRenB, busyB;
    logic [15:0] rdataB0, rdataB1, memAddrB, memDinB, memDoutB;

    logic [15:0] memArrA [0:255];
    logic [15:0] memArrB [0:255];

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic        port;
        logic [15:0] rdata;
        logic        isRead;
    } exp_t;

    typedef struct {
        int          cycles;
        logic        port;
        logic [15:0] rdata;
        int          renCyc;
        int          wenCyc;
        int          busyCyc;
        logic [15:0] addr;
        logic [15:0] din;
        logic        stable;
    } obs_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] din;
        logic        wen;
        logic        ren;
        logic        ack0;
        logic        ack1;
        logic [15:0] rd0;
        logic [15:0] rd1;
        logic        busy;
    } snap_t;

    exp_t sbQ[$];

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(1)) dutA (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(ackA0), .p0_rdata(rdataA0),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(ackA1), .p1_rdata(rdataA1),
        .mem_addr(memAddrA), .mem_din(memDinA), .mem_wen(memWenA), .mem_ren(memRenA),
        .mem_dout(memDoutA), .busy(busyA)
    );

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(3)) dutB (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(ackB0), .p0_rdata(rdataB0),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(ackB1), .p1_rdata(rdataB1),
        .mem_addr(memAddrB), .mem_din(memDinB), .mem_wen(memWenB), .mem_ren(memRenB),
        .mem_dout(memDoutB), .busy(busyB)
    );

    // Memory models: sample on negedge, drive z whenever ren is low.
    initial begin
        for (int i = 0; i < 256; i++) memArrA[i] = 16'h0000;
        memArrA[8'h10] = 16'hBEEF;
        memDoutA = 'z;
        forever begin
            @(negedge clk);
            if (memWenA) memArrA[memAddrA[7:0]] = memDinA;
            memDoutA = memRenA ? memArrA[memAddrA[7:0]] : 16'hzzzz;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) memArrB[i] = 16'h0000;
        memArrB[8'h10] = 16'hBEEF;
        memDoutB = 'z;
        forever begin
            @(negedge clk);
            if (memWenB) memArrB[memAddrB[7:0]] = memDinB;
            memDoutB = memRenB ? memArrB[memAddrB[7:0]] : 16'hzzzz;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic exp_t mkExp(input logic port, input logic [15:0] rdata, input logic isRead);
        exp_t e;
        e.port   = port;
        e.rdata  = rdata;
        e.isRead = isRead;
        return e;
    endfunction

    function automatic snap_t snap(input logic useB);
        snap_t s;
        if (useB) s = {memAddrB, memDinB, memWenB, memRenB, ackB0, ackB1, rdataB0, rdataB1, busyB};
        else      s = {memAddrA, memDinA, memWenA, memRenA, ackA0, ackA1, rdataA0, rdataA1, busyA};
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps clocks until an ack appears (bounded), recording what the memory side did meanwhile.
    task automatic waitAck(input logic useB, output obs_t obs);
        snap_t s;
        logic  first;
        obs.cycles = -1; obs.port = 1'b0; obs.rdata = '0;
        obs.renCyc = 0; obs.wenCyc = 0; obs.busyCyc = 0;
        obs.addr = '0; obs.din = '0; obs.stable = 1'b1;
        first = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            s = snap(useB);
            if (s.busy) obs.busyCyc++;
            if (s.ren) obs.renCyc++;
            if (s.wen) obs.wenCyc++;
            if (s.ren || s.wen) begin
                if (first) begin
                    obs.addr = s.addr;
                    obs.din  = s.din;
                    first    = 1'b0;
                end else if (s.addr !== obs.addr || s.din !== obs.din) begin
                    obs.stable = 1'b0;
                end
            end
            if (s.ack0 || s.ack1) begin
                obs.cycles = i;
                obs.port   = s.ack1;
                obs.rdata  = s.ack1 ? s.rd1 : s.rd0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        p0_req = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0;
        tick(); tick();
        testsRun++;
        if ({memAddrA, memDinA, memWenA, memRenA} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_memA: got %h expected 0", {memAddrA, memDinA, memWenA, memRenA});
        end
        testsRun++;
        if ({ackA0, ackA1, rdataA0, rdataA1, busyA} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_portA: got %h expected 0", {ackA0, ackA1, rdataA0, rdataA1, busyA});
        end
        testsRun++;
        if ({memAddrB, memDinB, memWenB, memRenB, ackB0, ackB1, busyB} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_B: got %h expected 0", {memAddrB, memDinB, memWenB, memRenB, ackB0, ackB1, busyB});
        end
        rst = 1'b0;
        tick();
        testsRun++;
        if ({busyA, memRenA, memWenA, ackA0, ackA1} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL idle_no_req: got %b expected 0", {busyA, memRenA, memWenA, ackA0, ackA1});
        end
    endtask

    task automatic test_single_read();
        obs_t obs;
        exp_t e;
        p0_wr = 0; p0_addr = 16'h0010; p0_req = 1;
        sbQ.push_back(mkExp(1'b0, 16'hBEEF, 1'b1));
        waitAck(1'b0, obs);
        p0_req = 0;
        testsRun++;
        if (obs.cycles !== 2) begin
            testsFailed++; $display("[TB] FAIL single_read_latency: got %0d expected 2", obs.cycles);
        end
        testsRun++;
        if (obs.renCyc !== 1 || obs.wenCyc !== 0 || obs.addr !== 16'h0010) begin
            testsFailed++;
            $display("[TB] FAIL single_read_mem: ren %0d wen %0d addr %h, expected 1 0 0010", obs.renCyc, obs.wenCyc, obs.addr);
        end
        testsRun++;
        if (sbQ.size() == 0) begin
            testsFailed++; $display("[TB] FAIL single_read_sb: scoreboard empty");
        end else begin
            e = sbQ.pop_front();
            if (obs.port !== e.port || obs.rdata !== e.rdata) begin
                testsFailed++;
                $display("[TB] FAIL single_read_data: port %b rdata %h expected %b %h", obs.port, obs.rdata, e.port, e.rdata);
            end
        end
        testsRun++;
        if (rdataA1 !== 16'h0000) begin
            testsFailed++; $display("[TB] FAIL single_read_p1_rdata: got %h expected 0000", rdataA1);
        end
        tick();
        testsRun++;
        if ({ackA0, ackA1, busyA} !== 3'b000) begin
            testsFailed++; $display("[TB] FAIL single_read_done: ack/busy %b expected 000", {ackA0, ackA1, busyA});
        end
    endtask

    task automatic test_write_read();
        obs_t obs;
        exp_t e;
        p1_wr = 1; p1_addr = 16'h0020; p1_wdata = 16'h1234; p1_req = 1;
        sbQ.push_back(mkExp(1'b1, 16'h0000, 1'b0));
        waitAck(1'b0, obs);
        p1_req = 0;
        testsRun++;
        if (obs.cycles !== 2 || obs.wenCyc !== 1 || obs.renCyc !== 0 || obs.din !== 16'h1234 || obs.addr !== 16'h0020) begin
            testsFailed++;
            $display("[TB] FAIL write_mem: cyc %0d wen %0d ren %0d din %h addr %h expected 2 1 0 1234 0020",
                     obs.cycles, obs.wenCyc, obs.renCyc, obs.din, obs.addr);
        end
        testsRun++;
        if (sbQ.size() == 0) begin
            testsFailed++; $display("[TB] FAIL write_sb: scoreboard empty");
        end else begin
            e = sbQ.pop_front();
            if (obs.port !== e.port || rdataA1 !== 16'h0000) begin
                testsFailed++;
                $display("[TB] FAIL write_ack: port %b p1_rdata %h expected %b 0000", obs.port, rdataA1, e.port);
            end
        end
        tick();
        p1_wr = 0; p1_req = 1;
        sbQ.push_back(mkExp(1'b1, 16'h1234, 1'b1));
        waitAck(1'b0, obs);
        p1_req = 0;
        testsRun++;
        if (obs.cycles !== 2) begin
            testsFailed++; $display("[TB] FAIL read_back_latency: got %0d expected 2", obs.cycles);
        end
        testsRun++;
        if (sbQ.size() == 0) begin
            testsFailed++; $display("[TB] FAIL read_back_sb: scoreboard empty");
        end else begin
            e = sbQ.pop_front();
            if (obs.port !== e.port || obs.rdata !== e.rdata) begin
                testsFailed++;
                $display("[TB] FAIL read_back_data: port %b rdata %h expected %b %h", obs.port, obs.rdata, e.port, e.rdata);
            end
        end
        testsRun++;
        if (rdataA0 !== 16'hBEEF) begin
            testsFailed++; $display("[TB] FAIL read_back_p0_untouched: got %h expected BEEF", rdataA0);
        end
        tick();
    endtask

    task automatic test_contention();
        obs_t obs;
        exp_t e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        p0_wr = 0; p0_addr = 16'h0010; p0_req = 1;
        p1_wr = 0; p1_addr = 16'h0020; p1_req = 1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sbQ.push_back(mkExp(1'b0, 16'hBEEF, 1'b1));
            else            sbQ.push_back(mkExp(1'b1, 16'h1234, 1'b1));
        end
        for (int k = 0; k < 4; k++) begin
            waitAck(1'b0, obs);
            testsRun++;
            if (obs.cycles !== ((k == 0) ? 2 : 3)) begin
                testsFailed++;
                $display("[TB] FAIL contention_spacing[%0d]: got %0d expected %0d", k, obs.cycles, (k == 0) ? 2 : 3);
            end
            testsRun++;
            if (sbQ.size() == 0) begin
                testsFailed++; $display("[TB] FAIL contention_sb[%0d]: scoreboard empty", k);
            end else begin
                e = sbQ.pop_front();
                if (obs.port !== e.port || obs.rdata !== e.rdata) begin
                    testsFailed++;
                    $display("[TB] FAIL contention_order[%0d]: port %b rdata %h expected %b %h", k, obs.port, obs.rdata, e.port, e.rdata);
                end
            end
        end
        p0_req = 0; p1_req = 0;
        tick();
    endtask

    task automatic test_late_request();
        obs_t obs;
        exp_t e;
        p0_wr = 0; p0_addr = 16'h0010; p0_req = 1;
        sbQ.push_back(mkExp(1'b0, 16'hBEEF, 1'b1));
        tick();
        p0_addr = 16'h0055;
        p1_wr = 0; p1_addr = 16'h0020; p1_req = 1;
        sbQ.push_back(mkExp(1'b1, 16'h1234, 1'b1));
        testsRun++;
        if (memAddrA !== 16'h0010 || memRenA !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL late_addr_latched: addr %h ren %b expected 0010 1", memAddrA, memRenA);
        end
        for (int k = 0; k < 3; k++) begin
            waitAck(1'b0, obs);
            if (k == 0) begin
                p0_addr = 16'h0010;
                sbQ.push_back(mkExp(1'b0, 16'hBEEF, 1'b1));
            end else if (k == 1) begin
                p1_req = 0;
            end else begin
                p0_req = 0;
            end
            testsRun++;
            if (obs.cycles !== ((k == 0) ? 1 : 3)) begin
                testsFailed++;
                $display("[TB] FAIL late_latency[%0d]: got %0d expected %0d", k, obs.cycles, (k == 0) ? 1 : 3);
            end
            testsRun++;
            if (sbQ.size() == 0) begin
                testsFailed++; $display("[TB] FAIL late_sb[%0d]: scoreboard empty", k);
            end else begin
                e = sbQ.pop_front();
                if (obs.port !== e.port || obs.rdata !== e.rdata) begin
                    testsFailed++;
                    $display("[TB] FAIL late_order[%0d]: port %b rdata %h expected %b %h", k, obs.port, obs.rdata, e.port, e.rdata);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        obs_t obs;
        exp_t e;
        p1_wr = 1; p1_addr = 16'h0030; p1_wdata = 16'hDEAD; p1_req = 1;
        tick();
        testsRun++;
        if (memWenA !== 1'b1 || busyA !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL rst_mid_grant: wen %b busy %b expected 1 1", memWenA, busyA);
        end
        rst = 1'b1;
        #1;
        testsRun++;
        if ({memWenA, memRenA, memAddrA, memDinA, busyA, ackA0, ackA1} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL rst_mid_clear: wen %b ren %b addr %h din %h busy %b acks %b%b expected all 0",
                     memWenA, memRenA, memAddrA, memDinA, busyA, ackA0, ackA1);
        end
        p1_req = 0;
        tick(); tick();
        rst = 1'b0;
        p0_wr = 0; p0_addr = 16'h0030; p0_req = 1;
        p1_wr = 0; p1_addr = 16'h0010; p1_req = 1;
        sbQ.push_back(mkExp(1'b0, 16'h0000, 1'b1));
        sbQ.push_back(mkExp(1'b1, 16'hBEEF, 1'b1));
        for (int k = 0; k < 2; k++) begin
            waitAck(1'b0, obs);
            if (k == 0) p0_req = 0;
            else        p1_req = 0;
            testsRun++;
            if (obs.cycles !== ((k == 0) ? 2 : 3)) begin
                testsFailed++;
                $display("[TB] FAIL rst_after_latency[%0d]: got %0d expected %0d", k, obs.cycles, (k == 0) ? 2 : 3);
            end
            testsRun++;
            if (sbQ.size() == 0) begin
                testsFailed++; $display("[TB] FAIL rst_after_sb[%0d]: scoreboard empty", k);
            end else begin
                e = sbQ.pop_front();
                if (obs.port !== e.port || obs.rdata !== e.rdata) begin
                    testsFailed++;
                    $display("[TB] FAIL rst_after_order[%0d]: port %b rdata %h expected %b %h", k, obs.port, obs.rdata, e.port, e.rdata);
                end
            end
        end
        tick();
    endtask

    task automatic test_access_cycles();
        obs_t obs;
        exp_t e;
        p0_req = 0; p1_req = 0;
        repeat (12) tick();
        p0_wr = 0; p0_addr = 16'h0010; p0_req = 1;
        sbQ.push_back(mkExp(1'b0, 16'hBEEF, 1'b1));
        waitAck(1'b1, obs);
        p0_req = 0;
        testsRun++;
        if (obs.cycles !== 4) begin
            testsFailed++; $display("[TB] FAIL ac3_latency: got %0d expected 4", obs.cycles);
        end
        testsRun++;
        if (obs.renCyc !== 3 || obs.wenCyc !== 0 || obs.stable !== 1'b1 || obs.addr !== 16'h0010) begin
            testsFailed++;
            $display("[TB] FAIL ac3_mem: ren %0d wen %0d stable %b addr %h expected 3 0 1 0010",
                     obs.renCyc, obs.wenCyc, obs.stable, obs.addr);
        end
        testsRun++;
        if (obs.busyCyc !== 4) begin
            testsFailed++; $display("[TB] FAIL ac3_busy: got %0d expected 4", obs.busyCyc);
        end
        testsRun++;
        if (sbQ.size() == 0) begin
            testsFailed++; $display("[TB] FAIL ac3_sb: scoreboard empty");
        end else begin
            e = sbQ.pop_front();
            if (obs.port !== e.port || obs.rdata !== e.rdata) begin
                testsFailed++;
                $display("[TB] FAIL ac3_data: port %b rdata %h expected %b %h", obs.port, obs.rdata, e.port, e.rdata);
            end
        end
        tick();
        testsRun++;
        if ({busyB, ackB0, ackB1} !== 3'b000) begin
            testsFailed++; $display("[TB] FAIL ac3_done: busy/acks %b expected 000", {busyB, ackB0, ackB1});
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_late_request();
        test_reset_mid_access();
        test_access_cycles();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the shared 16-bit byte-addressed data memory, which samples its inputs and updates dout on the clock negedge.
- Port 0 is the load/store unit; port 1 is the secondary requester (fetch/debug/DMA).
- Grants one requester at a time with round-robin fairness.
- Drives the memory's address/din/wen/ren from registers, captures read data, and returns a one-cycle ack.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data width in bits.
- ACCESS_CYCLES, 1, number of cycles mem_ren/mem_wen are held per access (1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 request; held high until p0_ack.
- p0_wr  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  port 0 one-cycle completion pulse.
- p0_rdata  out  DATA_W  port 0 read data; valid with p0_ack on reads.
- p1_req, p1_wr, p1_addr, p1_wdata, p1_ack, p1_rdata: same as the port 0 signals, for port 1.
- mem_addr  out  ADDR_W  to memory address.
- mem_din  out  DATA_W  to memory din.
- mem_wen  out  1  to memory wen.
- mem_ren  out  1  to memory ren.
- mem_dout  in  DATA_W  from memory dout.
- busy  out  1  high while not IDLE.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; last_grant = 1, so port 0 wins the first contention.
  - wait counter = 0.
  - All outputs 0: mem_*, acks, rdata, busy.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - Requests are sampled only in IDLE.
  - No req: stay in IDLE.
  - One req: grant it.
  - Both reqs: grant the port != last_grant.
  - On the granting posedge:
    - latch winner id, wr, addr, wdata;
    - set mem_addr = addr, mem_din = wdata, mem_wen = wr, mem_ren = ~wr;
    - set last_grant = winner; counter = ACCESS_CYCLES-1; go to ACCESS.
- ACCESS:
  - mem_* held stable for ACCESS_CYCLES cycles, so every memory negedge sees stable inputs.
  - counter decrements each posedge.
  - On the posedge where counter == 0:
    - if read, capture mem_dout into the winner's rdata;
    - deassert mem_wen, mem_ren; set mem_addr and mem_din to 0;
    - assert the winner's ack; go to DONE.
- DONE:
  - The ack is high for exactly this cycle.
  - Next posedge: ack = 0, go to IDLE.
  - The requester drops req (or presents a new request) in the cycle after ack.
- Latency:
  - req sampled at edge N; ack is high during cycle N+ACCESS_CYCLES+1.
  - Throughput is one access per ACCESS_CYCLES+2 cycles.
- rdata:
  - Holds its last captured value until the next read on that port.
  - Writes do not modify rdata.
  - The non-winning port's rdata never changes.
- mem_dout is sampled only at the end of a read ACCESS, never while mem_ren = 0 (memory drives z then).
- Request inputs:
  - Changes to addr/wdata/wr after the grant are ignored.
  - A req dropped before grant produces no access.
  - A req asserted while busy waits until IDLE.
- Simultaneous events: if p1 requests during a p0 access and p0 re-requests after its ack, p1 wins the next IDLE cycle. Round-robin guarantees neither port waits more than one access.
- Address arithmetic: none. The address is passed through unchanged; word-straddle and wrap at 0xFFFF belong to the memory.
- Reset mid-ACCESS:
  - all mem_* clear immediately and no ack is issued;
  - the write completes only if a negedge occurred before rst rose.
- busy = (state != IDLE).

Test Plan:
- Single read: memory word at 0x0010 = 0xBEEF; p0 read 0x0010 -> mem_ren high 1 cycle with mem_addr = 0x0010; p0_ack 2 cycles after grant edge; p0_rdata = 0xBEEF; p1_ack stays 0.
- Write then read: p1 write 0x0020 <- 0x1234, then p1 read 0x0020 -> mem_wen 1 cycle with mem_din = 0x1234; read returns 0x1234; p1_rdata unchanged by the write.
- Contention: p0 and p1 request in the same cycle from reset -> p0 granted first. Both keep requesting -> grant order p0, p1, p0, p1; acks spaced 3 cycles apart.
- ACCESS_CYCLES = 3: p0 read -> mem_ren high exactly 3 cycles with stable mem_addr; ack 4 cycles after grant; busy high 4 cycles.
- Reset mid-access: assert rst in the first ACCESS cycle of a p1 write -> mem_wen, busy, and acks 0 immediately. After release, p0 and p1 contend -> p0 granted.
- Late request: p1 raises req during a p0 access -> p1 granted on the first IDLE edge after p0's DONE; p0 addr changes after grant do not alter mem_addr.
